clint_responder: RTL and testbench
==================================

Name: clint_responder

Overview:
- Memory-bus responder for the core-local interruptor (CLINT); sits on the CPU memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) as a slave.
- Holds msip, 64-bit mtime and 64-bit mtimecmp.
- Drives the machine software interrupt (IRQ3, MSIP) and machine timer interrupt (IRQ7, MTIP) consumed by the CSR exception handler.
- Exports mtime as the 64-bit time base.

Parameters:
- BASE_ADDR, 32'h0200_0000, CLINT window base; decoded on mem_addr[31:16].
- SYSTEM_CLK, 50_000_000, core clock in Hz.
- TIMER_HZ, 10_000_000, mtime increment rate in Hz. DIV = SYSTEM_CLK/TIMER_HZ, elaboration error if DIV < 1.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  request strobe, held by the initiator until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address
- mem_wstrb  in  4  byte write enables; 0 means read
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid while mem_ready=1
- IRQ3  out  1  MSIP, equals msip[0]
- IRQ7  out  1  MTIP, registered (mtime >= mtimecmp)
- mtime  out  64  current timer value

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values:
  - mem_ready=0, mem_rdata=0
  - msip=0, IRQ3=0
  - mtime=0, prescaler=0
  - mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, IRQ7=0
  - FSM=IDLE
- Select condition: sel = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]).
- Register map, offset = mem_addr[15:0], word aligned; mem_addr[1:0] is ignored:
  - 0x0000 msip. Only bit0 is writable (byte0 strobe). Reads return {31'b0, msip}.
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other offset in the window: reads return 0, writes are ignored, and the transaction still completes.
- FSM:
  - IDLE: if sel, register the write (per-byte strobes) and the read data at this edge, then go to RESP.
  - RESP: mem_ready=1, rdata stable; always returns to IDLE.
  - Latency: ready is seen in the second cycle of the request.
  - If mem_valid is still high in the IDLE cycle after RESP, it is treated as a new transaction. The initiator must drop valid after ready.
  - The responder never asserts mem_ready when sel=0.
- Read data: the value at the accept edge, before that edge's tick or write is applied.
- Prescaler: counts 0..DIV-1. At DIV-1 it wraps to 0 and produces tick. When DIV=1, tick is asserted every cycle.
- mtime: on tick, mtime <= mtime + 1 with full 64-bit carry; wraps from 2^64-1 to 0.
- Simultaneous tick and write to an mtime word:
  - The written bytes take the written value.
  - The unwritten bytes of that word take the incremented value.
  - The other word is unchanged; no carry propagates into or out of the written word in that cycle.
  - The prescaler is not reset by mtime writes.
- IRQ7: updated every cycle from the current mtime and mtimecmp, so it lags a register change by one cycle.
  - It deasserts one cycle after software writes mtimecmp above mtime.
  - A transient is possible between hi and lo word writes; this is accepted, since software uses the standard hi=all-ones sequence.
- IRQ3: combinational from msip; changes in the cycle after the write edge.
- Reset mid-transaction: FSM returns to IDLE and mem_ready drops immediately. A pending write is not applied unless its edge has already occurred.

Decomposition:
- Shared package/header holds:
  - offsets CLINT_MSIP=16'h0000, CLINT_MTIMECMP_LO=16'h4000, CLINT_MTIMECMP_HI=16'h4004, CLINT_MTIME_LO=16'hBFF8, CLINT_MTIME_HI=16'hBFFC
  - FSM state encoding CLINT_IDLE and CLINT_RESP
- One sub-module: timer_prescaler (parameter DIV; ports clk, resetn, tick), instanced once.

Test Plan:
- Reset, then read 0x0200_4004 -> mem_ready exactly one cycle, in the 2nd cycle of the request; rdata=32'hFFFF_FFFF. Read 0x0200_BFF8 -> a small nonzero count consistent with DIV; IRQ7=0.
- Write 0x0200_0000 wdata=1 wstrb=4'b0001 -> IRQ3=1 next cycle. Write wdata=0 -> IRQ3=0. Write wdata=1 wstrb=4'b0010 -> IRQ3 unchanged.
- DIV=5: write mtime_lo=0, mtime_hi=0, mtimecmp_hi=0, mtimecmp_lo=10 -> IRQ7 rises 1 cycle after mtime reaches 10 (about 50 clocks). Write mtimecmp_hi=1 -> IRQ7=0 the cycle after.
- Write mtime_lo=32'hFFFF_FFFF, mtime_hi=0, wait one tick -> mtime=64'h1_0000_0000. Write during a tick cycle -> written value wins, no carry into hi.
- Read 0x0200_1234 -> rdata=0 with ready. Write to the same offset -> no register changes. Request at 0x1000_0000 -> mem_ready stays 0.
- Assert resetn=0 during RESP with a write to mtimecmp_lo in flight -> mem_ready=0 immediately. After release, mtimecmp=all-ones if the write edge had not occurred.

Source files
------------

// File: rtl/clint_responder_pkg.sv
// Shared definitions for the CLINT memory-bus responder: register offsets,
// responder FSM states and byte-lane helpers.
package clint_responder_pkg;

   localparam logic [15:0] CLINT_MSIP        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   typedef enum logic {
      CLINT_IDLE = 1'b0,
      CLINT_RESP = 1'b1
   } clint_state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] wr_word,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) merged[i*8 +: 8] = wr_word[i*8 +: 8];
      end
      return merged;
   endfunction

   // Offsets compare on word granularity; the byte-select bits never matter.
   function automatic logic word_match(input logic [15:0] offset,
                                       input logic [15:0] reg_offset);
      return offset[15:2] == reg_offset[15:2];
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock down to the mtime increment rate: one tick every DIV
// cycles, or every cycle when DIV is 1.
module timer_prescaler #(
   parameter int DIV = 5
) (
   input  logic clk,
   input  logic resetn,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   count <= '0;
      else if (tick) count <= '0;
      else           count <= count + CW'(1);
   end

endmodule

// File: rtl/clint_responder.sv
// CLINT slave on the CPU memory bus: msip, mtime and mtimecmp registers, the
// MSIP/MTIP interrupt lines, and mtime exported as the system time base.
module clint_responder
   import clint_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
   parameter int          SYSTEM_CLK = 50_000_000,
   parameter int          TIMER_HZ   = 10_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        IRQ3,
   output logic        IRQ7,
   output logic [63:0] mtime
);

   localparam int DIV = SYSTEM_CLK / TIMER_HZ;

   clint_state_e state, state_next;
   logic         sel, accept, wr, tick, msip;
   logic [15:0]  offset;
   logic [31:0]  read_word;
   logic [63:0]  mtimecmp, mtime_inc, mtime_next;
   logic         unused_addr_bits;

   if (DIV < 1) begin : g_div_check
      $error("clint_responder: SYSTEM_CLK / TIMER_HZ must be at least 1");
      assign tick = 1'b0;
   end else begin : g_prescaler
      timer_prescaler #(.DIV(DIV)) u_prescaler (
         .clk    (clk),
         .resetn (resetn),
         .tick   (tick)
      );
   end

   assign sel              = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]);
   assign offset           = mem_addr[15:0];
   assign wr               = accept && (mem_wstrb != 4'b0000);
   assign IRQ3             = msip;
   assign unused_addr_bits = ^mem_addr[1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= CLINT_IDLE;
      else         state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      mem_ready  = 1'b0;
      unique case (state)
         CLINT_IDLE: if (sel) begin
            accept     = 1'b1;
            state_next = CLINT_RESP;
         end
         CLINT_RESP: begin
            mem_ready  = 1'b1;
            state_next = CLINT_IDLE;
         end
      endcase
   end

   always_comb begin
      read_word = '0;
      if      (word_match(offset, CLINT_MSIP))        read_word = {31'b0, msip};
      else if (word_match(offset, CLINT_MTIMECMP_LO)) read_word = mtimecmp[31:0];
      else if (word_match(offset, CLINT_MTIMECMP_HI)) read_word = mtimecmp[63:32];
      else if (word_match(offset, CLINT_MTIME_LO))    read_word = mtime[31:0];
      else if (word_match(offset, CLINT_MTIME_HI))    read_word = mtime[63:32];
   end

   // A write to one mtime word freezes the other word and cuts the carry
   // between them; unwritten bytes of a written low word still advance.
   always_comb begin
      mtime_inc  = mtime + 64'd1;
      mtime_next = tick ? mtime_inc : mtime;
      if (wr && word_match(offset, CLINT_MTIME_LO))
         mtime_next = {mtime[63:32], byte_merge(mtime_next[31:0], mem_wdata, mem_wstrb)};
      else if (wr && word_match(offset, CLINT_MTIME_HI))
         mtime_next = {byte_merge(mtime[63:32], mem_wdata, mem_wstrb), mtime[31:0]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         msip      <= 1'b0;
         mtime     <= '0;
         mtimecmp  <= '1;
         IRQ7      <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mtime <= mtime_next;
         IRQ7  <= (mtime >= mtimecmp);
         if (accept) mem_rdata <= read_word;
         if (wr && word_match(offset, CLINT_MSIP) && mem_wstrb[0])
            msip <= mem_wdata[0];
         if (wr && word_match(offset, CLINT_MTIMECMP_LO))
            mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], mem_wdata, mem_wstrb);
         if (wr && word_match(offset, CLINT_MTIMECMP_HI))
            mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], mem_wdata, mem_wstrb);
      end
   end

endmodule

// File: tb/tb_clint_responder.sv
// Self-checking bench for clint_responder: directed scenarios plus random bus
// traffic, checked against a transaction-level model of the CLINT registers.
module tb_clint_responder;

   localparam int          DIV    = 5;
   localparam logic [31:0] A_MSIP = 32'h0200_0000;
   localparam logic [31:0] A_CMPL = 32'h0200_4000;
   localparam logic [31:0] A_CMPH = 32'h0200_4004;
   localparam logic [31:0] A_MTL  = 32'h0200_BFF8;
   localparam logic [31:0] A_MTH  = 32'h0200_BFFC;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_addr = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        IRQ3, IRQ7;
   logic [63:0] mtime;

   int n_cmp = 0;
   int n_bad = 0;

   clint_responder #(
      .BASE_ADDR  (32'h0200_0000),
      .SYSTEM_CLK (50_000_000),
      .TIMER_HZ   (10_000_000)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .IRQ3      (IRQ3),
      .IRQ7      (IRQ7),
      .mtime     (mtime)
   );

   always #5 clk = ~clk;

   // Reference model: register contents as the software-visible map describes.
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_irq7, m_busy;
   logic [31:0] m_rdata;
   int unsigned m_edges;

   function automatic logic [31:0] m_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [15:0] word_off);
      case (word_off)
         16'h0000: return {31'b0, m_msip};
         16'h4000: return m_cmp[31:0];
         16'h4004: return m_cmp[63:32];
         16'hBFF8: return m_mtime[31:0];
         16'hBFFC: return m_mtime[63:32];
         default:  return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge resetn) begin : model
      logic        tk, acc;
      logic [63:0] nt;
      logic [15:0] off;
      if (!resetn) begin
         m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_irq7 = 1'b0;
         m_busy = 1'b0; m_rdata = '0; m_edges = 0;
      end else begin
         tk = (m_edges % DIV) == DIV - 1;
         m_edges++;
         acc = mem_valid && (mem_addr[31:16] == 16'h0200) && !m_busy;
         m_busy = acc;
         m_irq7 = (m_mtime >= m_cmp);
         nt = m_mtime + (tk ? 64'd1 : 64'd0);
         if (acc) begin
            off = {mem_addr[15:2], 2'b00};
            m_rdata = m_read(off);
            if (mem_wstrb != 4'b0) begin
               case (off)
                  16'h0000: if (mem_wstrb[0]) m_msip = mem_wdata[0];
                  16'h4000: m_cmp[31:0]  = m_merge(m_cmp[31:0], mem_wdata, mem_wstrb);
                  16'h4004: m_cmp[63:32] = m_merge(m_cmp[63:32], mem_wdata, mem_wstrb);
                  16'hBFF8: nt = {m_mtime[63:32], m_merge(nt[31:0], mem_wdata, mem_wstrb)};
                  16'hBFFC: nt = {m_merge(m_mtime[63:32], mem_wdata, mem_wstrb), m_mtime[31:0]};
                  default: ;
               endcase
            end
         end
         m_mtime = nt;
      end
   end

   // One bus transaction from a falling edge: ready sampled in the request's
   // first cycle, second cycle and the cycle after valid is dropped.
   task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                       output logic [2:0] rdy, output logic [31:0] rdata);
      mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wdata;
      #1 rdy[2] = mem_ready;
      @(negedge clk);
      rdy[1] = mem_ready; rdata = mem_rdata;
      mem_valid = 1'b0; mem_wstrb = '0;
      @(negedge clk);
      rdy[0] = mem_ready;
   endtask

   task automatic align_to_tick();
      for (int i = 0; i < 2 * DIV && (m_edges % DIV) != DIV - 1; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [2:0] rdy; logic [31:0] rd;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_ready, IRQ3, IRQ7} !== 3'b000) begin
         n_bad++; $display("FAIL reset_flags got %b exp 000", {mem_ready, IRQ3, IRQ7});
      end
      n_cmp++;
      if ({mem_rdata, mtime} !== 96'h0) begin
         n_bad++; $display("FAIL reset_data got rdata=%h mtime=%h exp 0", mem_rdata, mtime);
      end
      resetn = 1'b1;
      xfer(A_CMPH, 4'h0, 32'h0, rdy, rd);
      n_cmp++;
      if (rdy !== 3'b010) begin n_bad++; $display("FAIL reset_rd_ready got %b exp 010", rdy); end
      n_cmp++;
      if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp_hi got %h exp ffffffff", rd); end
      repeat (12) @(negedge clk);
      xfer(A_MTL, 4'h0, 32'h0, rdy, rd);
      n_cmp++;
      if (rd !== m_rdata || rd == 32'h0 || rd > 32'd4) begin
         n_bad++; $display("FAIL reset_mtime_rd got %h exp %h", rd, m_rdata);
      end
      n_cmp++;
      if (IRQ7 !== 1'b0) begin n_bad++; $display("FAIL reset_irq7 got %b exp 0", IRQ7); end
   endtask

   task automatic test_msip();
      logic [2:0] rdy; logic [31:0] rd;
      logic [3:0]  strbs [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      logic [31:0] datas [4] = '{32'h1, 32'h0, 32'h1, 32'h0};
      logic        exps  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1; mem_addr = A_MSIP; mem_wstrb = strbs[i]; mem_wdata = datas[i];
         @(negedge clk);
         mem_valid = 1'b0; mem_wstrb = '0;
         n_cmp++;
         if (IRQ3 !== exps[i]) begin
            n_bad++; $display("FAIL msip_write%0d got IRQ3=%b exp %b", i, IRQ3, exps[i]);
         end
         @(negedge clk);
      end
      xfer(A_MSIP | 32'h3, 4'h0, 32'h0, rdy, rd);
      n_cmp++;
      if (rd !== 32'h1) begin n_bad++; $display("FAIL msip_read got %h exp 00000001", rd); end
      xfer(A_MSIP, 4'hF, 32'hFFFF_FFFE, rdy, rd);
      n_cmp++;
      if (IRQ3 !== 1'b0) begin n_bad++; $display("FAIL msip_clear got %b exp 0", IRQ3); end
   endtask

   task automatic test_timer();
      logic [2:0] rdy; logic [31:0] rd;
      bit rose = 0;
      xfer(A_MTL, 4'hF, 32'h0, rdy, rd);
      xfer(A_MTH, 4'hF, 32'h0, rdy, rd);
      xfer(A_CMPH, 4'hF, 32'h0, rdy, rd);
      xfer(A_CMPL, 4'hF, 32'd10, rdy, rd);
      for (int i = 0; i < 120 && !rose; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({mtime, IRQ7} !== {m_mtime, m_irq7}) begin
            n_bad++; $display("FAIL timer_track got mtime=%h irq7=%b exp %h %b", mtime, IRQ7, m_mtime, m_irq7);
         end
         if (IRQ7 === 1'b1) begin
            rose = 1;
            n_cmp++;
            if (mtime !== 64'd10) begin n_bad++; $display("FAIL timer_rise_at got %0d exp 10", mtime); end
         end
      end
      n_cmp++;
      if (!rose) begin n_bad++; $display("FAIL timer_timeout got irq7=0 exp 1 within 120 cycles"); end
      xfer(A_CMPH, 4'hF, 32'h1, rdy, rd);
      n_cmp++;
      if (IRQ7 !== 1'b0) begin n_bad++; $display("FAIL timer_cmp_raise got irq7=%b exp 0", IRQ7); end
   endtask

   task automatic test_carry();
      logic [2:0] rdy; logic [31:0] rd;
      xfer(A_MTH, 4'hF, 32'h0, rdy, rd);
      xfer(A_MTL, 4'hF, 32'hFFFF_FFFF, rdy, rd);
      for (int i = 0; i < 3 * DIV && m_mtime[63:32] == 32'h0; i++) @(negedge clk);
      n_cmp++;
      if (mtime !== 64'h1_0000_0000) begin
         n_bad++; $display("FAIL carry got %h exp 0000000100000000", mtime);
      end
   endtask

   task automatic test_write_on_tick();
      logic [2:0] rdy; logic [31:0] rd;
      xfer(A_MTH, 4'hF, 32'h7, rdy, rd);
      align_to_tick();
      xfer(A_MTL, 4'hF, 32'hFFFF_FFFF, rdy, rd);
      n_cmp++;
      if (mtime !== 64'h7_FFFF_FFFF) begin n_bad++; $display("FAIL tick_wr_lo1 got %h exp 00000007ffffffff", mtime); end
      align_to_tick();
      xfer(A_MTL, 4'hF, 32'h1234_5678, rdy, rd);
      n_cmp++;
      if (mtime !== 64'h7_1234_5678) begin n_bad++; $display("FAIL tick_wr_nocarry got %h exp 0000000712345678", mtime); end
      align_to_tick();
      xfer(A_MTL, 4'b0011, 32'hAAAA_BBBB, rdy, rd);
      n_cmp++;
      if (mtime !== 64'h7_1234_BBBB) begin n_bad++; $display("FAIL tick_wr_partial got %h exp 000000071234bbbb", mtime); end
      align_to_tick();
      xfer(A_MTH, 4'hF, 32'hCAFE_0000, rdy, rd);
      n_cmp++;
      if (mtime !== 64'hCAFE_0000_1234_BBBB) begin n_bad++; $display("FAIL tick_wr_hi got %h exp cafe00001234bbbb", mtime); end
   endtask

   task automatic test_unmapped();
      logic [2:0] rdy; logic [31:0] rd;
      bit seen = 0;
      xfer(32'h0200_1234, 4'h0, 32'h0, rdy, rd);
      n_cmp++;
      if ({rdy, rd} !== {3'b010, 32'h0}) begin n_bad++; $display("FAIL unmapped_read got %b/%h exp 010/0", rdy, rd); end
      xfer(32'h0200_1234, 4'hF, 32'hFFFF_FFFF, rdy, rd);
      n_cmp++;
      if ({rdy, mtime, IRQ3, IRQ7} !== {3'b010, m_mtime, m_msip, m_irq7}) begin
         n_bad++; $display("FAIL unmapped_write got %b %h %b %b exp 010 %h %b %b", rdy, mtime, IRQ3, IRQ7, m_mtime, m_msip, m_irq7);
      end
      xfer(A_CMPL, 4'h0, 32'h0, rdy, rd);
      n_cmp++;
      if (rd !== 32'd10) begin n_bad++; $display("FAIL unmapped_cmp_kept got %h exp 0000000a", rd); end
      mem_valid = 1'b1; mem_addr = 32'h1000_0000; mem_wstrb = 4'hF; mem_wdata = 32'h1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_ready !== 1'b0) seen = 1;
      end
      mem_valid = 1'b0; mem_wstrb = '0;
      n_cmp++;
      if (seen) begin n_bad++; $display("FAIL outside_window got mem_ready=1 exp 0"); end
      n_cmp++;
      if (IRQ3 !== m_msip) begin n_bad++; $display("FAIL outside_window_msip got %b exp %b", IRQ3, m_msip); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      mem_valid = 1'b1; mem_addr = A_CMPL; mem_wstrb = 4'h0;
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         pat[i] = mem_ready;
      end
      mem_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (pat !== 4'b1010) begin n_bad++; $display("FAIL back_to_back got %b exp 1010", pat); end
   endtask

   task automatic test_random();
      logic [2:0] rdy; logic [31:0] rd, addr;
      logic [31:0] offs [6] = '{A_MSIP, A_CMPL, A_CMPH, A_MTL, A_MTH, 32'h0200_0100};
      for (int t = 0; t < 40; t++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            @(negedge clk);
            n_cmp++;
            if ({mtime, IRQ3, IRQ7} !== {m_mtime, m_msip, m_irq7}) begin
               n_bad++; $display("FAIL rand_idle%0d got %h %b %b exp %h %b %b", t, mtime, IRQ3, IRQ7, m_mtime, m_msip, m_irq7);
            end
         end
         addr = offs[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
         xfer(addr, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom, rdy, rd);
         n_cmp++;
         if ({rdy, rd} !== {3'b010, m_rdata}) begin
            n_bad++; $display("FAIL rand_xfer%0d addr=%h got %b/%h exp 010/%h", t, addr, rdy, rd, m_rdata);
         end
         n_cmp++;
         if ({mtime, IRQ3, IRQ7} !== {m_mtime, m_msip, m_irq7}) begin
            n_bad++; $display("FAIL rand_state%0d got %h %b %b exp %h %b %b", t, mtime, IRQ3, IRQ7, m_mtime, m_msip, m_irq7);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] rdy; logic [31:0] rd;
      for (int k = 0; k < 2; k++) begin
         mem_valid = 1'b1; mem_addr = A_CMPL; mem_wstrb = 4'hF; mem_wdata = 32'h55;
         if (k == 0) @(posedge clk);
         #2 resetn = 1'b0;
         #1;
         n_cmp++;
         if ({mem_ready, mem_rdata} !== 33'h0) begin
            n_bad++; $display("FAIL reset_mid%0d got ready=%b rdata=%h exp 0", k, mem_ready, mem_rdata);
         end
         mem_valid = 1'b0; mem_wstrb = '0;
         @(negedge clk);
         resetn = 1'b1;
         xfer(A_CMPL, 4'h0, 32'h0, rdy, rd);
         n_cmp++;
         if ({rdy, rd} !== {3'b010, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL reset_mid_cmp%0d got %b/%h exp 010/ffffffff", k, rdy, rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_msip();
      test_timer();
      test_carry();
      test_write_on_tick();
      test_unmapped();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
